// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 make-code to ASCII decoder with a ready/valid output buffer.
// Define PS2_DECODER_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module ps2_scancode_decoder #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ps2_received_data,
  input  logic       ps2_received_data_strb,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       char_dropped
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BREAK,
    S_EXT_BREAK
  } state_t;

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BREAK = 8'hF0;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end

  // Returns {hit, ascii} for a set-2 make code.
  function automatic logic [8:0] map_code(input logic [7:0] code);
    logic [8:0] r;
    case (code)
      8'h1C: r = {1'b1, 8'h41};  8'h32: r = {1'b1, 8'h42};
      8'h21: r = {1'b1, 8'h43};  8'h23: r = {1'b1, 8'h44};
      8'h24: r = {1'b1, 8'h45};  8'h2B: r = {1'b1, 8'h46};
      8'h34: r = {1'b1, 8'h47};  8'h33: r = {1'b1, 8'h48};
      8'h43: r = {1'b1, 8'h49};  8'h3B: r = {1'b1, 8'h4A};
      8'h42: r = {1'b1, 8'h4B};  8'h4B: r = {1'b1, 8'h4C};
      8'h3A: r = {1'b1, 8'h4D};  8'h31: r = {1'b1, 8'h4E};
      8'h44: r = {1'b1, 8'h4F};  8'h4D: r = {1'b1, 8'h50};
      8'h15: r = {1'b1, 8'h51};  8'h2D: r = {1'b1, 8'h52};
      8'h1B: r = {1'b1, 8'h53};  8'h2C: r = {1'b1, 8'h54};
      8'h3C: r = {1'b1, 8'h55};  8'h2A: r = {1'b1, 8'h56};
      8'h1D: r = {1'b1, 8'h57};  8'h22: r = {1'b1, 8'h58};
      8'h35: r = {1'b1, 8'h59};  8'h1A: r = {1'b1, 8'h5A};
      8'h45: r = {1'b1, 8'h30};  8'h16: r = {1'b1, 8'h31};
      8'h1E: r = {1'b1, 8'h32};  8'h26: r = {1'b1, 8'h33};
      8'h25: r = {1'b1, 8'h34};  8'h2E: r = {1'b1, 8'h35};
      8'h36: r = {1'b1, 8'h36};  8'h3D: r = {1'b1, 8'h37};
      8'h3E: r = {1'b1, 8'h38};  8'h46: r = {1'b1, 8'h39};
      8'h29: r = {1'b1, 8'h20};  8'h5A: r = {1'b1, 8'h0D};
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  state_t     state;
  logic       hit;
  logic [7:0] ascii;
  logic       push_req;
  logic       pop;
  logic       push_ok;
  logic       drop;

  always_comb begin
    {hit, ascii} = map_code(ps2_received_data);
    push_req     = ps2_received_data_strb && (state == S_IDLE) && hit;
    pop          = char_valid && char_ready;
  end

  // Prefix tracking: E0 marks extended keys, F0 marks a release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (ps2_received_data_strb) begin
      case (state)
        S_IDLE: begin
          if (ps2_received_data == CODE_EXT)        state <= S_EXT;
          else if (ps2_received_data == CODE_BREAK) state <= S_BREAK;
        end
        S_EXT: begin
          if (ps2_received_data == CODE_BREAK)      state <= S_EXT_BREAK;
          else if (ps2_received_data != CODE_EXT)   state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PS2_DECODER_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_next;
  logic [CW-1:0] count;
  logic [CW-1:0] remaining;
  logic          full;

  always_comb begin
    full      = (count == CW'(FIFO_DEPTH));
    push_ok   = push_req && (!full || pop);
    drop      = push_req && full && !pop;
    rd_next   = rd_ptr + AW'(pop);
    remaining = count - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= ascii;
  end

  // Output head is registered; a push into an empty buffer bypasses the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      char_data    <= 8'h00;
      char_valid   <= 1'b0;
      char_dropped <= 1'b0;
    end else begin
      rd_ptr       <= rd_next;
      wr_ptr       <= wr_ptr + AW'(push_ok);
      count        <= remaining + CW'(push_ok);
      char_valid   <= (remaining != '0) || push_ok;
      char_dropped <= drop;
      if (remaining != '0)  char_data <= mem[rd_next];
      else if (push_ok)     char_data <= ascii;
    end
  end
`else
  always_comb begin
    push_ok = push_req && (!char_valid || pop);
    drop    = push_req && char_valid && !pop;
  end

  // Single holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_data    <= 8'h00;
      char_valid   <= 1'b0;
      char_dropped <= 1'b0;
    end else begin
      char_valid   <= push_ok || (char_valid && !pop);
      char_dropped <= drop;
      if (push_ok) char_data <= ascii;
    end
  end
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder against a queue-based reference model.
// Works with or without PS2_DECODER_FIFO_EN.
module tb_ps2_scancode_decoder;

`ifdef PS2_DECODER_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] ps2_received_data;
  logic       ps2_received_data_strb;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;
  logic       char_dropped;

  ps2_scancode_decoder #(.FIFO_DEPTH(4)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .ps2_received_data      (ps2_received_data),
    .ps2_received_data_strb (ps2_received_data_strb),
    .char_data              (char_data),
    .char_valid             (char_valid),
    .char_ready             (char_ready),
    .char_dropped           (char_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Scan codes listed in alphabet / digit order; ASCII is the table index offset.
  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  // Reference model state
  logic [7:0] q [$];
  bit         after_ext;
  bit         after_break;
  bit         exp_drop;
  bit         exp_valid;
  logic [7:0] exp_data;

  function automatic bit ref_map(input logic [7:0] c, output logic [7:0] a);
    a = 8'h00;
    for (int i = 0; i < 26; i++) if (letters[i] == c) begin a = 8'(8'h41 + i); return 1'b1; end
    for (int i = 0; i < 10; i++) if (digits[i] == c) begin a = 8'(8'h30 + i); return 1'b1; end
    if (c == 8'h29) begin a = 8'h20; return 1'b1; end
    if (c == 8'h5A) begin a = 8'h0D; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    after_ext   = 1'b0;
    after_break = 1'b0;
    exp_drop    = 1'b0;
    exp_valid   = 1'b0;
    exp_data    = 8'h00;
  endtask

  // Drive one cycle of inputs, advance the model, and return at the next negedge.
  task automatic drive(input logic s, input logic [7:0] d, input logic r);
    logic [7:0] a;
    bit hit, pop, push;
    ps2_received_data_strb = s;
    ps2_received_data      = d;
    char_ready             = r;
    hit  = ref_map(d, a);
    pop  = (q.size() != 0) && r;
    push = 1'b0;
    if (s) begin
      if (after_break) begin
        after_break = 1'b0;
        after_ext   = 1'b0;
      end else if (after_ext) begin
        if (d == 8'hF0) begin after_break = 1'b1; after_ext = 1'b0; end
        else if (d != 8'hE0) after_ext = 1'b0;
      end else if (d == 8'hE0) after_ext = 1'b1;
      else if (d == 8'hF0) after_break = 1'b1;
      else push = hit;
    end
    exp_drop = push && (q.size() == CAP) && !pop;
    if (pop) void'(q.pop_front());
    if (push && !exp_drop) q.push_back(a);
    @(negedge clk);
    ps2_received_data_strb = 1'b0;
    exp_valid = (q.size() != 0);
    exp_data  = exp_valid ? q[0] : 8'h00;
  endtask

  task automatic test_reset();
    ps2_received_data_strb = 1'b0;
    ps2_received_data      = 8'h00;
    char_ready             = 1'b0;
    rst_n                  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if (char_valid !== 1'b0 || char_data !== 8'h00 || char_dropped !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: valid=%b data=%h drop=%b, want valid=0 data=00 drop=0",
               char_valid, char_data, char_dropped);
    end
  endtask

  task automatic test_release_ignored();
    logic [7:0] seq [7] = '{8'h1C, 8'hF0, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00};
    int n_chars = 0;
    for (int i = 0; i < 7; i++) begin
      drive(i < 3, seq[i], 1'b1);
      n_cmp++;
      if (char_valid !== exp_valid || char_dropped !== exp_drop || (exp_valid && char_data !== exp_data)) begin
        n_bad++;
        $display("FAIL release step %0d: valid=%b data=%h drop=%b, want valid=%b data=%h drop=%b",
                 i, char_valid, char_data, char_dropped, exp_valid, exp_data, exp_drop);
      end
      if (char_valid === 1'b1) n_chars++;
      if (i == 0) begin
        n_cmp++;
        if (char_valid !== 1'b1 || char_data !== 8'h41) begin
          n_bad++;
          $display("FAIL make_latency: valid=%b data=%h, want valid=1 data=41", char_valid, char_data);
        end
      end
    end
    n_cmp++;
    if (n_chars != 1) begin
      n_bad++;
      $display("FAIL release_count: got %0d valid cycles, want 1", n_chars);
    end
  endtask

  task automatic test_extended();
    logic [7:0] seq [6] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h29};
    logic [7:0] got [$];
    for (int i = 0; i < 9; i++) begin
      if (char_valid === 1'b1) got.push_back(char_data);
      drive(i < 6, (i < 6) ? seq[i] : 8'h00, 1'b1);
      n_cmp++;
      if (char_valid !== exp_valid || char_dropped !== exp_drop || (exp_valid && char_data !== exp_data)) begin
        n_bad++;
        $display("FAIL extended step %0d: valid=%b data=%h drop=%b, want valid=%b data=%h drop=%b",
                 i, char_valid, char_data, char_dropped, exp_valid, exp_data, exp_drop);
      end
    end
    n_cmp++;
    if (got.size() != 1 || got[0] !== 8'h20) begin
      n_bad++;
      $display("FAIL extended_output: got %0d chars (first %h), want one char 20",
               got.size(), (got.size() != 0) ? got[0] : 8'hxx);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [6] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36};
    logic [7:0] want  [4] = '{8'h31, 8'h32, 8'h33, 8'h34};
    logic [7:0] got [$];
    int drops = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, codes[i], 1'b0);
      n_cmp++;
      if (char_valid !== exp_valid || char_dropped !== exp_drop || (exp_valid && char_data !== exp_data)) begin
        n_bad++;
        $display("FAIL overflow fill %0d: valid=%b data=%h drop=%b, want valid=%b data=%h drop=%b",
                 i, char_valid, char_data, char_dropped, exp_valid, exp_data, exp_drop);
      end
      if (char_dropped === 1'b1) drops++;
    end
    n_cmp++;
    if (drops != 6 - CAP) begin
      n_bad++;
      $display("FAIL overflow_drops: got %0d, want %0d", drops, 6 - CAP);
    end
    for (int i = 0; i < CAP + 2; i++) begin
      if (char_valid === 1'b1) got.push_back(char_data);
      drive(1'b0, 8'h00, 1'b1);
    end
    n_cmp++;
    if (got.size() != CAP) begin
      n_bad++;
      $display("FAIL drain_count: got %0d, want %0d", got.size(), CAP);
    end else begin
      for (int i = 0; i < CAP; i++) begin
        n_cmp++;
        if (got[i] !== want[i]) begin
          n_bad++;
          $display("FAIL drain_order %0d: got %h, want %h", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_push_on_full_pop();
    for (int i = 0; i < CAP; i++) drive(1'b1, digits[i], 1'b0);
    drive(1'b1, 8'h1C, 1'b1);
    n_cmp++;
    if (char_dropped !== 1'b0 || char_valid !== 1'b1 || char_data !== exp_data) begin
      n_bad++;
      $display("FAIL full_pop_push: drop=%b valid=%b data=%h, want drop=0 valid=1 data=%h",
               char_dropped, char_valid, char_data, exp_data);
    end
    for (int i = 0; i < CAP + 1; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (char_valid !== exp_valid || (exp_valid && char_data !== exp_data)) begin
        n_bad++;
        $display("FAIL full_pop_drain %0d: valid=%b data=%h, want valid=%b data=%h",
                 i, char_valid, char_data, exp_valid, exp_data);
      end
    end
  endtask

  task automatic test_reset_mid_sequence();
    drive(1'b1, 8'h16, 1'b0);
    drive(1'b1, 8'h1E, 1'b0);
    drive(1'b1, 8'hF0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (char_valid !== 1'b0 || char_dropped !== 1'b0 || char_data !== 8'h00) begin
      n_bad++;
      $display("FAIL async_reset: valid=%b data=%h drop=%b, want valid=0 data=00 drop=0",
               char_valid, char_data, char_dropped);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'h1C, 1'b1);
    n_cmp++;
    if (char_valid !== 1'b1 || char_data !== 8'h41) begin
      n_bad++;
      $display("FAIL restart_idle: valid=%b data=%h, want valid=1 data=41", char_valid, char_data);
    end
    drive(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    b = 8'hE0;
        2:       b = 8'hF0;
        3, 4, 5: b = letters[$urandom_range(0, 25)];
        6:       b = digits[$urandom_range(0, 9)];
        default: b = 8'($urandom);
      endcase
      drive(1'($urandom_range(0, 2) != 0), b, 1'($urandom_range(0, 3) == 0));
      n_cmp++;
      if (char_valid !== exp_valid || char_dropped !== exp_drop || (exp_valid && char_data !== exp_data)) begin
        n_bad++;
        $display("FAIL random cycle %0d: valid=%b data=%h drop=%b, want valid=%b data=%h drop=%b",
                 i, char_valid, char_data, char_dropped, exp_valid, exp_data, exp_drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_release_ignored();
    test_extended();
    test_overflow();
    test_push_on_full_pop();
    test_reset_mid_sequence();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of two, 2..16; used only with PS2_DECODER_FIFO_EN).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ps2_received_data  input  8  scan-code byte from the PS/2 receiver.
REQ-005 SHALL have port ps2_received_data_strb  input  1  one-cycle strobe, byte valid.
REQ-006 SHALL have port char_data  output  8  ASCII character at buffer head.
REQ-007 SHALL have port char_valid  output  1  char_data holds a character.
REQ-008 SHALL have port char_ready  input  1  consumer accepts char_data when char_valid is high.
REQ-009 SHALL have port char_dropped  output  1  one-cycle pulse, mapped character lost because the buffer was full.

Function
REQ-010 SHALL decode with 4 states: S_IDLE, S_EXT (after E0), S_BREAK (after F0), S_EXT_BREAK (after E0 F0); state changes only on a cycle with ps2_received_data_strb=1.
REQ-011 S_IDLE: E0 -> S_EXT; F0 -> S_BREAK; mapped make code -> push ASCII, stay; any other byte -> ignored, stay.
REQ-012 S_EXT: F0 -> S_EXT_BREAK; E0 -> stay; any other byte -> S_IDLE, no push (extended keys unmapped).
REQ-013 S_BREAK and S_EXT_BREAK: next byte of any value -> S_IDLE, no push (release ignored).
REQ-014 Mapping (set 2 make -> ASCII): letters map to uppercase 0x41..0x5A: A1C B32 C21 D23 E24 F2B G34 H33 I43 J3B K42 L4B M3A N31 O44 P4D Q15 R2D S1B T2C U3C V2A W1D X22 Y35 Z1A.
REQ-015 Digits map to 0x30..0x39: 0=45 1=16 2=1E 3=26 4=25 5=2E 6=36 7=3D 8=3E 9=46; 29 -> 0x20 (space); 5A -> 0x0D (enter).
REQ-016 Repeated make codes (typematic) SHALL each push a character.
REQ-017 Latency: strobe at cycle N with a mapped code SHALL give char_valid=1 with that char at cycle N+1 when the buffer was empty.
REQ-018 A pop SHALL occur on a cycle with char_valid=1 and char_ready=1; char_ready is ignored while char_valid=0.
REQ-019 char_data and char_valid SHALL stay stable while char_valid=1 and char_ready=0.
REQ-020 Push to a full buffer SHALL be dropped with char_dropped=1 at cycle N+1; a push coinciding with a pop on a full buffer SHALL be accepted, no drop.
REQ-021 Buffer order SHALL be FIFO; read/write pointers wrap modulo capacity.

Reset
REQ-022 On rst_n=0 (asynchronous): state=S_IDLE, buffer empty, char_valid=0, char_data=0x00, char_dropped=0.
REQ-023 A byte sequence in progress at reset SHALL be discarded; after release the decoder SHALL restart in S_IDLE.

Configuration
REQ-024 Macro PS2_DECODER_FIFO_EN defined: the buffer SHALL be a FIFO_DEPTH-entry FIFO.
REQ-025 Macro PS2_DECODER_FIFO_EN undefined: the buffer SHALL be a single holding register (capacity 1); FIFO_DEPTH ignored; REQ-017..021 apply with capacity 1.

Verification
REQ-026 Bytes 1C, F0, 1C with char_ready=1 -> exactly one char 0x41; char_valid high for one cycle.
REQ-027 Bytes E0 75, E0 F0 75, then 29 -> only 0x20 output; state returns to S_IDLE after each sequence.
REQ-028 With char_ready=0, FIFO_EN, depth 4: six make codes 16 1E 26 25 2E 36 -> chars 31 32 33 34 held in order; char_dropped pulses twice; then char_ready=1 drains 31,32,33,34.
REQ-029 Without FIFO_EN: 16 then 1E with char_ready=0 -> char_data 0x31 holds, one drop pulse; 1E strobed on the pop cycle -> accepted, 0x32 next.
REQ-030 rst_n low mid-sequence after F0 with 2 chars buffered -> char_valid=0 immediately; after release, 1C -> 0x41 (not swallowed as break).
